// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM: default geometry and clear/ready state.
package ram_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_DEPTH      = 2**DEF_ADDR_WIDTH;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   function automatic int depth_of(input int aw);
      return 2**aw;
   endfunction
endpackage

// File: rtl/ram_port_rd.sv
// Registered read stage for one RAM port: captures the array word on a read
// strobe, holds it otherwise, and pulses valid for one cycle.
module ram_port_rd #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_rd_en,
   input  logic [DATA_WIDTH-1:0] i_mem_data,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_rd_valid
);

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= i_rd_en;
         if (i_rd_en) r_data <= i_mem_data;
      end
   end

   assign o_rd_data  = r_data;
   assign o_rd_valid = r_valid;

endmodule

// File: rtl/dual_port_ram.sv
// True dual-port RAM with a post-reset clear sweep, port-A-wins write
// arbitration and a registered same-address write collision flag.
module dual_port_ram
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_wr_enb,
   input  logic                  a_rd_enb,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wr_data,
   output logic [DATA_WIDTH-1:0] a_rd_data,
   output logic                  a_rd_valid,
   input  logic                  b_wr_enb,
   input  logic                  b_rd_enb,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wr_data,
   output logic [DATA_WIDTH-1:0] b_rd_data,
   output logic                  b_rd_valid,
   output logic                  busy,
   output logic                  wr_collision
);

   localparam int DEPTH = depth_of(ADDR_WIDTH);

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_nxt;
   logic                  r_col;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_ready;
   logic                  w_same_addr;
   logic                  w_a_wr, w_b_wr, w_col;
   logic [DATA_WIDTH-1:0] w_a_mem, w_b_mem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= CLEAR;
         r_ptr   <= '0;
         r_col   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_col   <= w_col;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         CLEAR: begin
            w_ptr_nxt = r_ptr + 1'b1;
            if (r_ptr == ADDR_WIDTH'(DEPTH-1)) w_state_nxt = READY;
         end
         READY:   w_state_nxt = READY;
         default: w_state_nxt = CLEAR;
      endcase
   end

   assign w_ready     = (r_state == READY);
   assign w_same_addr = (a_addr == b_addr);
   assign w_a_wr      = w_ready & a_wr_enb;
   // Port A wins a same-address write; B's write is dropped entirely.
   assign w_b_wr      = w_ready & b_wr_enb & ~(a_wr_enb & w_same_addr);
   assign w_col       = w_ready & a_wr_enb & b_wr_enb & w_same_addr;

   always_ff @(posedge clk) begin
      if (!w_ready) begin
         r_mem[r_ptr] <= '0;
      end else begin
         if (w_b_wr) r_mem[b_addr] <= b_wr_data;
         if (w_a_wr) r_mem[a_addr] <= a_wr_data;
      end
   end

   // Reads sample the array before this edge's writes land (read-before-write).
   assign w_a_mem = r_mem[a_addr];
   assign w_b_mem = r_mem[b_addr];

   ram_port_rd #(.DATA_WIDTH(DATA_WIDTH)) u_rd_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rd_en    (w_ready & a_rd_enb),
      .i_mem_data (w_a_mem),
      .o_rd_data  (a_rd_data),
      .o_rd_valid (a_rd_valid)
   );

   ram_port_rd #(.DATA_WIDTH(DATA_WIDTH)) u_rd_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rd_en    (w_ready & b_rd_enb),
      .i_mem_data (w_b_mem),
      .o_rd_data  (b_rd_data),
      .o_rd_valid (b_rd_valid)
   );

   assign busy         = ~w_ready;
   assign wr_collision = r_col;

endmodule

// File: tb/tb_dual_port_ram.sv
// Randomized self-checking bench for dual_port_ram against a behavioural array model.
module tb_dual_port_ram;
   import ram_pkg::*;

   localparam int DW = DEF_DATA_WIDTH;
   localparam int AW = DEF_ADDR_WIDTH;
   localparam int D  = DEF_DEPTH;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_wr_enb, a_rd_enb, b_wr_enb, b_rd_enb;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wr_data, b_wr_data;
   logic [DW-1:0] a_rd_data, b_rd_data;
   logic          a_rd_valid, b_rd_valid, busy, wr_collision;

   dual_port_ram dut (
      .clk(clk), .rst_n(rst_n),
      .a_wr_enb(a_wr_enb), .a_rd_enb(a_rd_enb), .a_addr(a_addr),
      .a_wr_data(a_wr_data), .a_rd_data(a_rd_data), .a_rd_valid(a_rd_valid),
      .b_wr_enb(b_wr_enb), .b_rd_enb(b_rd_enb), .b_addr(b_addr),
      .b_wr_data(b_wr_data), .b_rd_data(b_rd_data), .b_rd_valid(b_rd_valid),
      .busy(busy), .wr_collision(wr_collision)
   );

   always #5 clk = ~clk;

   // Reference model: plain array plus expected output values.
   logic [DW-1:0] m_mem [D];
   int            clr_left;
   logic [DW-1:0] e_ad, e_bd;
   logic          e_av, e_bv, e_col, e_busy;
   int            n_chk = 0;
   int            n_pass = 0;

   task automatic idle();
      a_wr_enb = 0; a_rd_enb = 0; b_wr_enb = 0; b_rd_enb = 0;
      a_addr = '0; b_addr = '0; a_wr_data = '0; b_wr_data = '0;
   endtask

   task automatic rand_in(input int amax);
      a_wr_enb = 1'($urandom_range(0, 1)); a_rd_enb = 1'($urandom_range(0, 1));
      b_wr_enb = 1'($urandom_range(0, 1)); b_rd_enb = 1'($urandom_range(0, 1));
      a_addr = AW'($urandom_range(0, amax)); b_addr = AW'($urandom_range(0, amax));
      a_wr_data = DW'($urandom); b_wr_data = DW'($urandom);
   endtask

   task automatic model_reset();
      e_ad = '0; e_bd = '0; e_av = 0; e_bv = 0; e_col = 0; e_busy = 1;
      clr_left = D;
      for (int i = 0; i < D; i++) m_mem[i] = '0;
   endtask

   // Advance the model by one clock using the current inputs, then clock the DUT.
   task automatic step();
      if (rst_n) begin
         if (clr_left > 0) begin
            clr_left--;
            e_av = 0; e_bv = 0; e_col = 0;
         end else begin
            e_av = a_rd_enb; e_bv = b_rd_enb;
            if (a_rd_enb) e_ad = m_mem[a_addr];
            if (b_rd_enb) e_bd = m_mem[b_addr];
            e_col = a_wr_enb && b_wr_enb && (a_addr == b_addr);
            if (b_wr_enb) m_mem[b_addr] = b_wr_data;
            if (a_wr_enb) m_mem[a_addr] = a_wr_data;
         end
         e_busy = (clr_left > 0);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      int busy_cycles;
      idle();
      rst_n = 0;
      model_reset();
      #2;
      n_chk++;
      if (busy !== 1'b1 || a_rd_valid !== 1'b0 || b_rd_valid !== 1'b0 || wr_collision !== 1'b0
          || a_rd_data !== '0 || b_rd_data !== '0) begin
         $display("FAIL reset_state: busy=%b av=%b bv=%b col=%b ad=%h bd=%h, need busy=1 others 0",
                  busy, a_rd_valid, b_rd_valid, wr_collision, a_rd_data, b_rd_data);
      end else n_pass++;
      step(); step();
      rst_n = 1;
      busy_cycles = 0;
      for (int i = 0; i < D + 2 && e_busy; i++) begin
         rand_in(D - 1);
         step();
         busy_cycles++;
         n_chk++;
         if (busy !== e_busy || a_rd_valid !== 1'b0 || b_rd_valid !== 1'b0 || wr_collision !== 1'b0) begin
            $display("FAIL clear_sweep cyc %0d: busy=%b av=%b bv=%b col=%b, need busy=%b others 0",
                     i, busy, a_rd_valid, b_rd_valid, wr_collision, e_busy);
         end else n_pass++;
      end
      n_chk++;
      if (busy_cycles !== D || busy !== 1'b0) begin
         $display("FAIL clear_duration: %0d cycles busy=%b, need %0d cycles busy=0", busy_cycles, busy, D);
      end else n_pass++;
      idle();
   endtask

   task automatic test_sanity();
      a_wr_enb = 1; a_addr = 3; a_wr_data = 8'hA5;
      step();
      idle(); b_rd_enb = 1; b_addr = 3;
      step();
      n_chk++;
      if (b_rd_data !== 8'hA5 || b_rd_valid !== 1'b1 || b_rd_data !== e_bd) begin
         $display("FAIL sanity: b_rd_data=%h valid=%b, need a5 valid=1", b_rd_data, b_rd_valid);
      end else n_pass++;
      idle();
   endtask

   task automatic test_continuous();
      for (int i = 0; i < D; i++) begin
         idle(); a_wr_enb = 1; a_addr = AW'(i); a_wr_data = DW'(i);
         step();
      end
      for (int i = 0; i < D; i++) begin
         idle(); b_rd_enb = 1; b_addr = AW'(i);
         step();
         n_chk++;
         if (b_rd_data !== DW'(i) || b_rd_valid !== 1'b1 || a_rd_valid !== 1'b0) begin
            $display("FAIL continuous addr %0d: data=%h bv=%b av=%b, need %h bv=1 av=0",
                     i, b_rd_data, b_rd_valid, a_rd_valid, DW'(i));
         end else n_pass++;
      end
      idle();
      step();
      n_chk++;
      if (b_rd_valid !== 1'b0 || b_rd_data !== DW'(D - 1)) begin
         $display("FAIL read_hold: bv=%b data=%h, need bv=0 data=%h", b_rd_valid, b_rd_data, DW'(D - 1));
      end else n_pass++;
   endtask

   task automatic test_collision();
      idle();
      a_wr_enb = 1; a_addr = 7; a_wr_data = 8'h11;
      b_wr_enb = 1; b_addr = 7; b_wr_data = 8'h22;
      step();
      n_chk++;
      if (wr_collision !== 1'b1 || wr_collision !== e_col) begin
         $display("FAIL collision_flag: wr_collision=%b, need 1", wr_collision);
      end else n_pass++;
      idle(); a_rd_enb = 1; a_addr = 7;
      step();
      n_chk++;
      if (wr_collision !== 1'b0 || a_rd_data !== 8'h11 || a_rd_data !== e_ad) begin
         $display("FAIL collision_data: col=%b a_rd_data=%h, need col=0 data 11", wr_collision, a_rd_data);
      end else n_pass++;
      // Different addresses written together must not flag.
      idle();
      a_wr_enb = 1; a_addr = 1; a_wr_data = 8'h5A;
      b_wr_enb = 1; b_addr = 2; b_wr_data = 8'hC3;
      step();
      n_chk++;
      if (wr_collision !== 1'b0) begin
         $display("FAIL no_collision: wr_collision=%b, need 0", wr_collision);
      end else n_pass++;
      idle();
   endtask

   task automatic test_back_to_back();
      idle(); a_wr_enb = 1; a_addr = 5; a_wr_data = 8'h33;
      step();
      idle(); a_rd_enb = 1; a_addr = 5; b_wr_enb = 1; b_addr = 5; b_wr_data = 8'h44;
      step();
      n_chk++;
      if (a_rd_data !== 8'h33 || a_rd_valid !== 1'b1) begin
         $display("FAIL cross_rd_old: a_rd_data=%h valid=%b, need 33 valid=1", a_rd_data, a_rd_valid);
      end else n_pass++;
      // Same-port read+write: read returns pre-write contents.
      idle(); a_rd_enb = 1; a_addr = 5; a_wr_enb = 1; a_wr_data = 8'h55;
      step();
      n_chk++;
      if (a_rd_data !== 8'h44) begin
         $display("FAIL cross_wr_commit: a_rd_data=%h, need 44", a_rd_data);
      end else n_pass++;
      idle(); a_rd_enb = 1; a_addr = 5; b_rd_enb = 1; b_addr = 5;
      step();
      n_chk++;
      if (a_rd_data !== 8'h55 || b_rd_data !== 8'h55 || wr_collision !== 1'b0) begin
         $display("FAIL same_port_rw: a=%h b=%h col=%b, need 55 55 col=0", a_rd_data, b_rd_data, wr_collision);
      end else n_pass++;
      idle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         rand_in((i < 150) ? 3 : D - 1);
         step();
         n_chk++;
         if (a_rd_data !== e_ad || b_rd_data !== e_bd || a_rd_valid !== e_av || b_rd_valid !== e_bv
             || wr_collision !== e_col || busy !== e_busy) begin
            $display("FAIL random cyc %0d: ad=%h av=%b bd=%h bv=%b col=%b busy=%b, need %h %b %h %b %b %b",
                     i, a_rd_data, a_rd_valid, b_rd_data, b_rd_valid, wr_collision, busy,
                     e_ad, e_av, e_bd, e_bv, e_col, e_busy);
         end else n_pass++;
      end
      idle();
   endtask

   task automatic test_mid_reset();
      int busy_cycles;
      for (int i = 0; i < 11; i++) begin
         idle(); a_wr_enb = 1; a_addr = AW'(i); a_wr_data = 8'hFF;
         b_rd_enb = (i > 0); b_addr = AW'(i - 1);
         b_wr_enb = 1; b_addr = AW'(i + 5); b_wr_data = 8'hFF;
         if (i > 0) b_wr_enb = 0;
         step();
      end
      #2;
      rst_n = 0;
      model_reset();
      #1;
      n_chk++;
      if (busy !== 1'b1 || a_rd_valid !== 1'b0 || b_rd_valid !== 1'b0 || wr_collision !== 1'b0
          || a_rd_data !== '0 || b_rd_data !== '0) begin
         $display("FAIL mid_reset_clear: busy=%b av=%b bv=%b col=%b ad=%h bd=%h, need busy=1 others 0",
                  busy, a_rd_valid, b_rd_valid, wr_collision, a_rd_data, b_rd_data);
      end else n_pass++;
      rand_in(D - 1);
      step(); step();
      rst_n = 1;
      busy_cycles = 0;
      for (int i = 0; i < D + 2 && e_busy; i++) begin
         a_wr_enb = 1; a_rd_enb = 1; b_wr_enb = 1; b_rd_enb = 1;
         a_addr = AW'($urandom); b_addr = AW'($urandom); a_wr_data = 8'hFF; b_wr_data = 8'hFF;
         step();
         busy_cycles++;
         n_chk++;
         if (busy !== e_busy || a_rd_valid !== 1'b0 || b_rd_valid !== 1'b0 || wr_collision !== 1'b0) begin
            $display("FAIL mid_reset_sweep cyc %0d: busy=%b av=%b bv=%b col=%b, need busy=%b others 0",
                     i, busy, a_rd_valid, b_rd_valid, wr_collision, e_busy);
         end else n_pass++;
      end
      n_chk++;
      if (busy_cycles !== D || busy !== 1'b0) begin
         $display("FAIL mid_reset_duration: %0d cycles busy=%b, need %0d cycles busy=0", busy_cycles, busy, D);
      end else n_pass++;
      for (int i = 0; i < D; i++) begin
         idle(); a_rd_enb = 1; a_addr = AW'(i); b_rd_enb = 1; b_addr = AW'(D - 1 - i);
         step();
         n_chk++;
         if (a_rd_data !== 8'h00 || b_rd_data !== 8'h00 || a_rd_valid !== 1'b1 || b_rd_valid !== 1'b1) begin
            $display("FAIL cleared_read addr %0d: a=%h/%b b=%h/%b, need 00/1 00/1",
                     i, a_rd_data, a_rd_valid, b_rd_data, b_rd_valid);
         end else n_pass++;
      end
      idle();
   endtask

   initial begin
      idle();
      model_reset();
      test_reset();
      test_sanity();
      test_continuous();
      test_collision();
      test_back_to_back();
      test_random();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dual_port_ram.md
# dual_port_ram

True dual-port synchronous RAM: the design-under-test end of the dual-port RAM interface driven by the layered testbench's driver and sampled by its monitor. Two independent ports (A, B) share one storage array and one clock. After every reset an internal sweep clears all locations to zero before accesses are accepted. Same-address conflicts between ports are resolved deterministically and flagged.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH

- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- a_wr_enb  input  1  port A write strobe
- a_rd_enb  input  1  port A read strobe
- a_addr  input  ADDR_WIDTH  port A address
- a_wr_data  input  DATA_WIDTH  port A write data
- a_rd_data  output  DATA_WIDTH  port A read data
- a_rd_valid  output  1  a_rd_data valid this cycle
- b_wr_enb, b_rd_enb, b_addr, b_wr_data, b_rd_data, b_rd_valid: same as port A, for port B
- busy  output  1  clear sweep in progress; accesses ignored
- wr_collision  output  1  both ports wrote the same address last cycle

## Operation
- FSM states: CLEAR, READY.
- rst_n low: state = CLEAR, sweep pointer = 0, busy = 1, all other outputs 0. Array contents are not touched asynchronously.
- CLEAR: writes 0 to the location at the sweep pointer each cycle, then increments the pointer.
  - Once location DEPTH-1 is written, the FSM moves to READY. Busy falls in the following cycle.
  - All strobes on both ports are ignored. Read valid stays 0.
- READY, write: x_wr_enb = 1 stores x_wr_data at x_addr at the clock edge.
- READY, read: x_rd_enb = 1 registers mem[x_addr] into x_rd_data and sets x_rd_valid = 1 for exactly one cycle.
  - With no read, x_rd_data holds its last value and x_rd_valid = 0.
- Same port, read and write in one cycle: both occur. The read returns the old contents (read-before-write).
- Cross-port read/write to the same address: the read returns the old contents, and the write commits.
- Both ports write the same address: port A's data is stored. wr_collision = 1 for one cycle.
- Both ports read the same address: both return identical data. No flag.
- Reset asserted mid-operation (any state): outputs clear immediately.
  - An in-flight read is lost.
  - The sweep restarts from address 0 after rst_n rises.

## Timing
- Read latency: 1 cycle. The strobe at edge N gives data and valid after edge N.
- Write-to-read on the same address, back-to-back: a write at edge N followed by a read at edge N+1 returns the new data after N+1.
- Clear duration: DEPTH cycles after the first clk edge with rst_n high. busy = 1 through that edge, 0 afterwards.
- First accepted access: the first edge with busy = 0.
- wr_collision: registered. It asserts the cycle after the colliding edge.
- Address wrap: none needed. Every address is in range by width.

## Structure
- Shared package ram_pkg holds:
  - default DATA_WIDTH/ADDR_WIDTH localparams
  - the state enum typedef {CLEAR, READY}
  - DEPTH computation
- The testbench transaction class and scoreboard reference model import the same package.
- One sub-module, ram_port_rd, is natural: the per-port registered read stage (data/valid registers plus hold behaviour). It is instantiated twice.
- The clear FSM and the write arbitration stay in the top module.

## Test plan
- Sanity: after rst_n rises, wait until busy = 0 (16 cycles at default).
  - A writes 0xA5 to address 3. B reads address 3 the next cycle.
  - Required: b_rd_data = 0xA5, b_rd_valid = 1 one cycle after the read strobe.
- Continuous write: A writes 0x00..0x0F to addresses 0..15 on consecutive cycles. B then reads 0..15.
  - Required: every word matches, and valid is asserted for 16 consecutive cycles.
- Simultaneous write collision: A writes 0x11 and B writes 0x22 to address 7 in the same cycle.
  - Required: wr_collision = 1 in the next cycle. A later read of address 7 returns 0x11.
- Back-to-back read/write: address 5 holds 0x33. In one cycle A reads address 5 while B writes 0x44 to address 5.
  - Required: a_rd_data = 0x33. A read the next cycle returns 0x44.
- In-between reset: write 0xFF to all addresses, then pulse rst_n low mid-burst.
  - Required: outputs are 0 immediately and busy = 1 for 16 cycles.
  - Strobes during busy are ignored.
  - A read of any address after busy falls returns 0x00.
